// File: rtl/collision_pkg.sv
// Shared constants and types for the multi-tile player/ground collision scanner.
package collision_pkg;

  localparam int COL_DOWN  = 0;
  localparam int COL_UP    = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam int DEF_PLAYER_W = 47;
  localparam int DEF_PLAYER_H = 41;
  localparam int DEF_TILE_W   = 24 + 1;
  localparam int DEF_TILE_H   = 24;
  localparam int DEF_FOOT_L   = 20;
  localparam int DEF_FOOT_R   = 26;
  localparam int DEF_MARGIN   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/collision_tile_check.sv
// Combinational per-tile side-hit evaluation; sums are widened so nothing wraps near 0.
module collision_tile_check
  import collision_pkg::*;
#(
  parameter int X_W      = 10,
  parameter int Y_W      = 9,
  parameter int PLAYER_W = DEF_PLAYER_W,
  parameter int PLAYER_H = DEF_PLAYER_H,
  parameter int TILE_W   = DEF_TILE_W,
  parameter int TILE_H   = DEF_TILE_H,
  parameter int FOOT_L   = DEF_FOOT_L,
  parameter int FOOT_R   = DEF_FOOT_R,
  parameter int MARGIN   = DEF_MARGIN
) (
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  input  logic [X_W-1:0] tx,
  input  logic [Y_W-1:0] ty,
  input  logic           valid,
  output logic [3:0]     hit
);

  localparam int S_W = max_int(X_W, Y_W) + 2;

  localparam logic [S_W-1:0] K_FL  = S_W'(FOOT_L);
  localparam logic [S_W-1:0] K_FR  = S_W'(FOOT_R);
  localparam logic [S_W-1:0] K_PW  = S_W'(PLAYER_W);
  localparam logic [S_W-1:0] K_PH  = S_W'(PLAYER_H);
  localparam logic [S_W-1:0] K_TW  = S_W'(TILE_W);
  localparam logic [S_W-1:0] K_TH  = S_W'(TILE_H);
  localparam logic [S_W-1:0] K_M   = S_W'(MARGIN);
  localparam logic [S_W-1:0] K_M2  = S_W'(2 * MARGIN);

  logic [S_W-1:0] pxe, pye, txe, tye;
  logic           hwin, vov;

  assign pxe = S_W'(px);
  assign pye = S_W'(py);
  assign txe = S_W'(tx);
  assign tye = S_W'(ty);

  assign hwin = (pxe + K_FL >= txe) && (pxe + K_FR <= txe + K_TW);
  assign vov  = (pye + K_PH > tye) && (pye < tye + K_TH);

  always_comb begin
    hit = 4'b0000;
    if (valid) begin
      hit[COL_DOWN]  = hwin && (tye <= pye + K_PH) && (pye + K_PH <= tye + K_M);
      hit[COL_UP]    = hwin && (tye + K_TH <= pye) && (pye <= tye + K_TH + K_M2);
      hit[COL_RIGHT] = vov && (pxe + K_PW + K_M >= txe) && (pxe + K_PW <= txe + K_M);
      hit[COL_LEFT]  = vov && (pxe + K_M >= txe + K_TW) && (pxe <= txe + K_TW + K_M);
    end
  end

endmodule

// File: rtl/collision_scan.sv
// Frame-tick scan of a synchronous tile table, ORing per-side hits into a registered vector.
module collision_scan
  import collision_pkg::*;
#(
  parameter int NUM_TILES = 32,
  parameter int IDX_W     = 5,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int PLAYER_W  = 47,
  parameter int PLAYER_H  = 41,
  parameter int TILE_W    = 25,
  parameter int TILE_H    = 24,
  parameter int FOOT_L    = 20,
  parameter int FOOT_R    = 26,
  parameter int MARGIN    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [X_W-1:0]   x_player,
  input  logic [Y_W-1:0]   y_player,
  output logic [IDX_W-1:0] tile_addr,
  input  logic [X_W-1:0]   tile_x,
  input  logic [Y_W-1:0]   tile_y,
  input  logic             tile_valid,
  output logic             busy,
  output logic             done,
  output logic [3:0]       is_collision,
  output logic [Y_W-1:0]   land_y
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TILES - 1);

  state_t           state, state_nxt;
  logic             addr_vld;
  logic             data_vld_p1;
  logic [IDX_W-1:0] data_idx_p1;
  logic [X_W-1:0]   px_l;
  logic [Y_W-1:0]   py_l;
  logic [3:0]       acc_coll, acc_coll_nxt;
  logic [Y_W-1:0]   acc_land, acc_land_nxt;
  logic [3:0]       hit;
  logic             last;

  collision_tile_check #(
    .X_W(X_W), .Y_W(Y_W), .PLAYER_W(PLAYER_W), .PLAYER_H(PLAYER_H),
    .TILE_W(TILE_W), .TILE_H(TILE_H), .FOOT_L(FOOT_L), .FOOT_R(FOOT_R),
    .MARGIN(MARGIN)
  ) u_check (
    .px   (px_l),
    .py   (py_l),
    .tx   (tile_x),
    .ty   (tile_y),
    .valid(tile_valid && data_vld_p1 && (state == SCAN)),
    .hit  (hit)
  );

  assign acc_coll_nxt = acc_coll | hit;
  assign acc_land_nxt = (hit[COL_DOWN] && (tile_y < acc_land)) ? tile_y : acc_land;
  assign last         = data_vld_p1 && (data_idx_p1 == LAST_IDX);

  assign busy = (state == SCAN);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tile_addr    <= '0;
      addr_vld     <= 1'b0;
      data_vld_p1  <= 1'b0;
      acc_coll     <= '0;
      acc_land     <= '0;
      is_collision <= '0;
      land_y       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc_coll    <= '0;
            acc_land    <= '1;
            tile_addr   <= '0;
            addr_vld    <= 1'b1;
            data_vld_p1 <= 1'b0;
          end
        end
        SCAN: begin
          // Table read has one cycle of latency: data seen now belongs to last cycle's address.
          data_vld_p1 <= addr_vld;
          if (addr_vld) begin
            if (tile_addr == LAST_IDX) addr_vld <= 1'b0;
            else                       tile_addr <= tile_addr + 1'b1;
          end
          if (data_vld_p1) begin
            acc_coll <= acc_coll_nxt;
            acc_land <= acc_land_nxt;
          end
          if (last) begin
            is_collision <= acc_coll_nxt;
            if (acc_coll_nxt[COL_DOWN]) land_y <= acc_land_nxt;
          end
        end
        default: begin
          addr_vld    <= 1'b0;
          data_vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  // Player position and read index are pure data; no reset needed.
  always_ff @(posedge clk) begin
    data_idx_p1 <= tile_addr;
    if (state == IDLE && start) begin
      px_l <= x_player;
      py_l <= y_player;
    end
  end

endmodule
